// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB with memory timeout fault.
// Optional build macro CTRL_INSTRET_EN adds a 32-bit retired-instruction counter output (instret).
module multicycle_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  state,
`ifdef CTRL_INSTRET_EN
  output logic        fault,
  output logic [31:0] instret
`else
  output logic        fault
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  op_q;
  logic [15:0] wait_cnt;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic opcode_legal;
  logic in_access;
  logic timeout_hit;
  logic enter_access;

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);

  assign opcode_legal = (opcode == OP_R) || (opcode == OP_LOAD) ||
                        (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign in_access    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout_hit  = (wait_cnt == TIMEOUT_LAST);
  assign enter_access = (state_d != state_q) &&
                        ((state_d == S_FETCH) || (state_d == S_MEM));

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= 7'd0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
    end
  end

  // Wait counter restarts on every new memory access; mem_ready on the last allowed cycle still completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (enter_access) begin
      wait_cnt <= 16'd0;
    end else if (in_access && !mem_ready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: begin
        state_d = opcode_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (op_q)
          OP_R:               state_d = S_WB;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH:          state_d = S_FETCH;
          default:            state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready)        state_d = is_load ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // ir_write, pc_write and pc_branch follow mem_ready/branch_taken combinationally; the rest are Moore.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctrl   = ALU_IDLE;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: begin
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
      end
      S_EXEC: begin
        alu_ctrl  = is_branch ? ALU_SUB : ALU_ADD;
        pc_branch = is_branch && branch_taken;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        alu_ctrl = ALU_ADD;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
      end
      S_HALT: begin
        fault = 1'b1;
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

`ifdef CTRL_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = ((state_q == S_EXEC) && is_branch) ||
                  ((state_q == S_MEM) && is_store && mem_ready) ||
                  (state_q == S_WB);

  always_ff @(posedge clock) begin
    if (reset) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm (built with TIMEOUT_CYCLES=4).
// Each row drives {start, mem_ready, branch_taken, opcode} and expects a packed output vector.
module tb_multicycle_ctrl_fsm;

  logic        clock;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic        pc_branch;
  logic        reg_write;
  logic        mem_to_reg;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
  logic        fault;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  int checks = 0;
  int passes = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  // {state, mem_req, mem_we, ir_write, pc_write, pc_branch, reg_write, mem_to_reg, alu_ctrl, fault}
  localparam logic [14:0] E_IDLE       = {3'd0, 7'b0000000, 4'b0000, 1'b0};
  localparam logic [14:0] E_FETCH_RDY  = {3'd1, 7'b1011000, 4'b0000, 1'b0};
  localparam logic [14:0] E_FETCH_WAIT = {3'd1, 7'b1000000, 4'b0000, 1'b0};
  localparam logic [14:0] E_DECODE     = {3'd2, 7'b0000000, 4'b0000, 1'b0};
  localparam logic [14:0] E_EXEC_ADD   = {3'd3, 7'b0000000, 4'b0010, 1'b0};
  localparam logic [14:0] E_EXEC_SUB   = {3'd3, 7'b0000000, 4'b0110, 1'b0};
  localparam logic [14:0] E_EXEC_TAKEN = {3'd3, 7'b0000100, 4'b0110, 1'b0};
  localparam logic [14:0] E_MEM_RD     = {3'd4, 7'b1000000, 4'b0010, 1'b0};
  localparam logic [14:0] E_MEM_WR     = {3'd4, 7'b1100000, 4'b0010, 1'b0};
  localparam logic [14:0] E_WB_R       = {3'd5, 7'b0000010, 4'b0000, 1'b0};
  localparam logic [14:0] E_WB_LD      = {3'd5, 7'b0000011, 4'b0000, 1'b0};
  localparam logic [14:0] E_HALT       = {3'd6, 7'b0000000, 4'b0000, 1'b1};

  logic [14:0] obs;
  assign obs = {state, mem_req, mem_we, ir_write, pc_write, pc_branch,
                reg_write, mem_to_reg, alu_ctrl, fault};

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_branch    (pc_branch),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_ctrl     (alu_ctrl),
    .state        (state),
`ifdef CTRL_INSTRET_EN
    .fault        (fault),
    .instret      (instret)
`else
    .fault        (fault)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [24:0] r(input logic s, input logic rd, input logic b,
                                    input logic [6:0] op, input logic [14:0] e);
    return {s, rd, b, op, e};
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    opcode       = 7'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== E_IDLE) $display("[TB] FAIL reset_state: got %h want %h", obs, E_IDLE);
    else passes++;
    @(negedge clock);
    #1;
    checks++;
    if (obs !== E_IDLE) $display("[TB] FAIL idle_hold: got %h want %h", obs, E_IDLE);
    else passes++;
    @(negedge clock);
  endtask

  task automatic test_r_type();
    logic [24:0] rows [6] = '{
      r(1, 1, 0, OP_R, E_IDLE),
      r(0, 1, 0, OP_R, E_FETCH_RDY),
      r(0, 1, 0, OP_R, E_DECODE),
      r(0, 1, 0, OP_R, E_EXEC_ADD),
      r(0, 1, 0, OP_R, E_WB_R),
      r(0, 1, 0, OP_R, E_FETCH_RDY)
    };
    for (int i = 0; i < 6; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL r_type[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_load();
    logic [24:0] rows [8] = '{
      r(0, 1, 0, OP_LD, E_DECODE),
      r(0, 1, 0, OP_LD, E_EXEC_ADD),
      r(0, 0, 0, OP_LD, E_MEM_RD),
      r(0, 0, 0, OP_LD, E_MEM_RD),
      r(0, 0, 0, OP_LD, E_MEM_RD),
      r(0, 1, 0, OP_LD, E_MEM_RD),
      r(0, 1, 0, OP_LD, E_WB_LD),
      r(0, 1, 0, OP_LD, E_FETCH_RDY)
    };
    for (int i = 0; i < 8; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL load[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_store();
    logic [24:0] rows [4] = '{
      r(0, 1, 0, OP_ST, E_DECODE),
      r(0, 1, 0, OP_ST, E_EXEC_ADD),
      r(0, 1, 0, OP_ST, E_MEM_WR),
      r(0, 1, 0, OP_ST, E_FETCH_RDY)
    };
    for (int i = 0; i < 4; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL store[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_branch();
    logic [24:0] rows [7] = '{
      r(0, 1, 1, OP_BR, E_DECODE),
      r(0, 1, 1, OP_BR, E_EXEC_TAKEN),
      r(0, 1, 0, OP_BR, E_FETCH_RDY),
      r(0, 1, 0, OP_BR, E_DECODE),
      r(0, 1, 0, OP_BR, E_EXEC_SUB),
      r(0, 0, 1, OP_BR, E_FETCH_WAIT),
      r(0, 1, 1, OP_BR, E_FETCH_RDY)
    };
    for (int i = 0; i < 7; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL branch[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_fetch_timeout();
    logic [24:0] rows [16] = '{
      r(0, 1, 0, OP_R, E_DECODE),
      r(0, 1, 0, OP_R, E_EXEC_ADD),
      r(0, 1, 0, OP_R, E_WB_R),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 1, 0, OP_R, E_FETCH_RDY),
      r(0, 1, 0, OP_R, E_DECODE),
      r(0, 1, 0, OP_R, E_EXEC_ADD),
      r(0, 1, 0, OP_R, E_WB_R),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(0, 0, 0, OP_R, E_FETCH_WAIT),
      r(1, 1, 0, OP_R, E_HALT),
      r(0, 1, 0, OP_R, E_HALT)
    };
    for (int i = 0; i < 16; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL fetch_timeout[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_illegal_opcode();
    logic [24:0] rows [6] = '{
      r(1, 1, 0, OP_ADDI, E_IDLE),
      r(0, 1, 0, OP_ADDI, E_FETCH_RDY),
      r(0, 1, 0, OP_ADDI, E_DECODE),
      r(1, 1, 0, OP_ADDI, E_HALT),
      r(0, 1, 0, OP_ADDI, E_HALT),
      r(1, 1, 0, OP_R,    E_HALT)
    };
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL illegal_opcode[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_mem_timeout();
    logic [24:0] rows [9] = '{
      r(1, 1, 0, OP_ST, E_IDLE),
      r(0, 1, 0, OP_ST, E_FETCH_RDY),
      r(0, 1, 0, OP_ST, E_DECODE),
      r(0, 0, 0, OP_ST, E_EXEC_ADD),
      r(0, 0, 0, OP_ST, E_MEM_WR),
      r(0, 0, 0, OP_ST, E_MEM_WR),
      r(0, 0, 0, OP_ST, E_MEM_WR),
      r(0, 0, 0, OP_ST, E_MEM_WR),
      r(0, 1, 0, OP_ST, E_HALT)
    };
    do_reset();
    for (int i = 0; i < 9; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL mem_timeout[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [24:0] rows [5] = '{
      r(1, 1, 0, OP_LD, E_IDLE),
      r(0, 1, 0, OP_LD, E_FETCH_RDY),
      r(0, 1, 0, OP_LD, E_DECODE),
      r(0, 0, 0, OP_LD, E_EXEC_ADD),
      r(0, 0, 0, OP_LD, E_MEM_RD)
    };
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {start, mem_ready, branch_taken, opcode} = rows[i][24:15];
      #1;
      checks++;
      if (obs !== rows[i][14:0]) $display("[TB] FAIL reset_mid_mem[%0d]: got %h want %h", i, obs, rows[i][14:0]);
      else passes++;
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== E_MEM_RD) $display("[TB] FAIL reset_mid_mem_pre: got %h want %h", obs, E_MEM_RD);
    else passes++;
    @(negedge clock);
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) $display("[TB] FAIL reset_mid_mem_idle: got %h want %h", obs, E_IDLE);
    else passes++;
    @(negedge clock);
    #1;
    checks++;
    if (obs !== E_IDLE) $display("[TB] FAIL reset_mid_mem_hold: got %h want %h", obs, E_IDLE);
    else passes++;
    @(negedge clock);
  endtask

`ifdef CTRL_INSTRET_EN
  task automatic test_instret();
    logic [6:0] ops [4] = '{OP_R, OP_LD, OP_ST, OP_BR};
    int         lat [4] = '{4, 5, 4, 3};
    do_reset();
    #1;
    checks++;
    if (instret !== 32'd0) $display("[TB] FAIL instret_reset: got %h want %h", instret, 32'd0);
    else passes++;
    start     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      repeat (lat[i]) @(negedge clock);
    end
    #1;
    checks++;
    if (instret !== 32'd4) $display("[TB] FAIL instret_count: got %h want %h", instret, 32'd4);
    else passes++;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    opcode = OP_BR;
    @(negedge clock);
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (instret !== 32'd0) $display("[TB] FAIL instret_wrap: got %h want %h", instret, 32'd0);
    else passes++;
    @(negedge clock);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();
    test_reset();
    test_r_type();
    test_load();
    test_store();
    test_branch();
    test_fetch_timeout();
    test_illegal_opcode();
    test_mem_timeout();
    test_reset_mid_mem();
`ifdef CTRL_INSTRET_EN
    test_instret();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32 base datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It drives per-cycle enables for the PC, IR, register file, ALU and memory port, and uses the same opcode classes and ALU control encodings as the combinational control unit. It sits between the instruction register and the shared single-port memory interface.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles a memory access waits for mem_ready before a fault (range 1..65535).

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  leave IDLE and begin fetching
opcode  in  7  instr[6:0] from IR; sampled in DECODE only
branch_taken  in  1  compare result from ALU/branch unit; sampled in EXEC
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
ir_write  out  1  load IR from memory read data
pc_write  out  1  PC <= PC+4
pc_branch  out  1  PC <= branch target
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback mux selects memory data
alu_ctrl  out  4  0010 ADD, 0110 SUB, 0000 idle
state  out  3  current state encoding, for debug
fault  out  1  sticky; illegal opcode or memory timeout

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7+ are unreachable; if entered, go to HALT with fault set.
- On reset: state=IDLE; all outputs 0; op_q=0; timeout counter=0. Reset mid-access abandons the access with no further strobes.
- IDLE: all outputs 0. start=1 -> FETCH next cycle.
- FETCH: mem_req=1, mem_we=0. When mem_ready=1, in the same cycle: ir_write=1, pc_write=1, then -> DECODE.
- DECODE (1 cycle): latch opcode into op_q.
  - Next state EXEC for 0110011 (R), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH).
  - Any other opcode -> HALT, fault=1.
- EXEC (1 cycle): alu_ctrl=0010 for R/LOAD/STORE, 0110 for BRANCH.
  - R -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_branch=branch_taken this cycle, then -> FETCH (retire).
- MEM: alu_ctrl=0010, mem_req=1, mem_we=1 for STORE only. On mem_ready: LOAD -> WB; STORE -> FETCH (retire).
- WB (1 cycle): reg_write=1; mem_to_reg=1 for LOAD only; then -> FETCH (retire).
- HALT: all strobes 0, fault=1. Ignores start; exits only via reset.
- Output timing: ir_write, pc_write and pc_branch are Mealy (combinational on mem_ready/branch_taken). All other outputs are functions of state and op_q only.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each waiting cycle with mem_ready=0.
  - If mem_ready=0 while the counter equals TIMEOUT_CYCLES-1 -> HALT, fault=1, mem_req drops next cycle.
  - mem_ready=1 on that same cycle wins: access completes normally.
- Latency with mem_ready held 1: BRANCH 3 cycles, R 4, STORE 4, LOAD 5. Each wait cycle adds 1.
- start is level-insensitive outside IDLE.

Optional Feature:
CTRL_INSTRET_EN.
- Defined: adds output instret [31:0]. It resets to 0 and increments by 1 on every retire transition (EXEC->FETCH for BRANCH, MEM->FETCH for STORE, WB->FETCH). It wraps 0xFFFFFFFF -> 0 and holds in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, start pulse, opcode=0110011, mem_ready=1 -> states 1,2,3,5,1; ir_write/pc_write high in cycle 1 only; reg_write=1 in WB with mem_to_reg=0; alu_ctrl=0010 in EXEC.
- LOAD 0000011 with mem_ready low for 3 MEM cycles then high -> mem_req=1, mem_we=0 for 4 MEM cycles; WB has reg_write=1, mem_to_reg=1; total 8 cycles.
- STORE 0100011 -> mem_we=1 only in MEM; reg_write never asserted; back to FETCH after 4 cycles. BRANCH with branch_taken=1 -> pc_branch=1 in EXEC with alu_ctrl=0110; branch_taken=0 -> pc_branch=0.
- opcode=0010011 in DECODE -> state 6, fault=1 next cycle; start=1 pulses keep state 6 and fault=1 until reset.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> after 4 wait cycles state=6, fault=1. Repeat with mem_ready=1 on the 4th wait cycle -> DECODE, fault=0. Assert reset during MEM -> IDLE, all outputs 0 next cycle.
- CTRL_INSTRET_EN: run R, LOAD, STORE, BRANCH sequence -> instret=4. Force instret to 0xFFFFFFFF, retire one instruction -> 0.
